// File: rtl/gpio_input_port_pkg.sv
// Shared definitions for gpio_input_port.
// Contents:
//   - register window offsets
//   - bus responder state encodings
//   - the packed bus request payload
package gpio_input_port_pkg;

  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = 4;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] REG_STATE  = 4'h0;
  localparam logic [3:0] REG_EVENTS = 4'h4;
  localparam logic [3:0] REG_MASK   = 4'h8;

  // Bus responder states
  localparam logic [0:0] BUS_IDLE = 1'b0;
  localparam logic [0:0] BUS_ACK  = 1'b1;

  typedef struct packed {
    logic [BUS_DW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_SW-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/input_debounce.sv
// One input bit: 2-FF synchroniser followed by a stability-counting debouncer.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   pin          raw asynchronous pin level
//   level        debounced level (registered)
//   rise_c       combinational pulse: level goes 0->1 at the coming edge
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic rise_c
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;
  logic          flip_c;

  // Flip once the mismatch has been seen on DEBOUNCE_CYCLES consecutive edges
  assign flip_c = (sync1 != level) && (cnt == CNT_LAST);
  assign rise_c = flip_c && !level;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= pin;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (flip_c) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped debounced input port with sticky rising-edge events and a
// maskable level interrupt, on the picorv32 native memory bus.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   in_pins[NUM_INPUTS]         raw asynchronous pins
//   mem_valid/addr/wdata/wstrb  bus request (wstrb==0 is a read)
//   mem_ready, mem_rdata        one-cycle acknowledge and read data
//   irq                         |(EVENTS & IRQ_MASK)
module gpio_input_port
  import gpio_input_port_pkg::*;
#(
  parameter int unsigned NUM_INPUTS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic [31:0] BASE_ADDR       = 32'h0300_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_INPUTS-1:0] in_pins,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  irq
);

  mem_req_t              req_c;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] rise_c;
  logic [NUM_INPUTS-1:0] wmask_c;
  logic [NUM_INPUTS-1:0] wbits_c;
  logic [NUM_INPUTS-1:0] clr_c;
  logic [NUM_INPUTS-1:0] events_q;
  logic [NUM_INPUTS-1:0] mask_q;
  logic [NUM_INPUTS-1:0] mask_d;
  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic                  sel_c;
  logic                  wr_c;
  logic                  ready_d;
  logic [31:0]           rdata_c;
  logic [31:0]           rdata_d;
  logic [3:0]            off_c;
  logic                  unused_c;

  assign req_c    = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
  assign sel_c    = mem_valid && (req_c.addr[31:4] == BASE_ADDR[31:4]);
  assign wr_c     = |req_c.wstrb;
  assign off_c    = {req_c.addr[3:2], 2'b00};
  assign wbits_c  = req_c.wdata[NUM_INPUTS-1:0];
  assign unused_c = ^{req_c.addr[1:0], req_c.wdata, req_c.wstrb};

  // Per-bit input conditioning and per-bit byte-lane write enable
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bit
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .resetn(resetn),
      .pin   (in_pins[i]),
      .level (level[i]),
      .rise_c(rise_c[i])
    );
    assign wmask_c[i] = req_c.wstrb[i / 8];
  end

  // Read mux over the pre-edge register values
  always_comb begin
    rdata_c = '0;
    case (off_c)
      REG_STATE:  rdata_c = 32'(level);
      REG_EVENTS: rdata_c = 32'(events_q);
      REG_MASK:   rdata_c = 32'(mask_q);
      default:    rdata_c = '0;
    endcase
  end

  // Bus responder next state, registered-output values and write decode
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    rdata_d = '0;
    mask_d  = mask_q;
    clr_c   = '0;
    case (state_q)
      BUS_IDLE: begin
        if (sel_c) begin
          state_d = BUS_ACK;
          ready_d = 1'b1;
          rdata_d = rdata_c;
          if (wr_c) begin
            if (off_c == REG_EVENTS) clr_c = wbits_c & wmask_c;
            if (off_c == REG_MASK)   mask_d = (mask_q & ~wmask_c) | (wbits_c & wmask_c);
          end
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  // State register; a new rise beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= BUS_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      events_q  <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      mem_ready <= ready_d;
      mem_rdata <= rdata_d;
      events_q  <= (events_q & ~clr_c) | rise_c;
      mask_q    <= mask_d;
    end
  end

  assign irq = |(events_q & mask_q);

endmodule

// File: tb/tb_gpio_input_port.sv
// Randomised scoreboard bench for gpio_input_port (8 inputs, 4-cycle debounce).
module tb_gpio_input_port;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk;
  logic        resetn;
  logic [7:0]  in_pins;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_level  = '0;
  logic [7:0]  m_events = '0;
  logic [7:0]  m_mask   = '0;
  bit          m_ack    = 0;
  logic [7:0]  hist[$];
  logic [31:0] exp_q[$];

  gpio_input_port #(
    .NUM_INPUTS     (8),
    .DEBOUNCE_CYCLES(D),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_pins  (in_pins),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a bit's level flips once the synchronised pin has
  // disagreed with it on the last D samples; the pin seen at edge e is the
  // one sampled at edge e-2.
  always @(posedge clk) begin : model
    logic [7:0] rd, clr, new_mask, new_level, s;
    bit         all_diff;
    if (!resetn) begin
      m_level  = '0;
      m_events = '0;
      m_mask   = '0;
      m_ack    = 0;
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(8'h00);
    end else begin
      clr      = '0;
      new_mask = m_mask;
      if (!m_ack && mem_valid && (mem_addr[31:4] == BASE[31:4])) begin
        case (mem_addr[3:2])
          2'd0:    rd = m_level;
          2'd1:    rd = m_events;
          2'd2:    rd = m_mask;
          default: rd = 8'h00;
        endcase
        exp_q.push_back({24'h0, rd});
        if (mem_wstrb[0]) begin
          if (mem_addr[3:2] == 2'd1) clr = mem_wdata[7:0];
          if (mem_addr[3:2] == 2'd2) new_mask = mem_wdata[7:0];
        end
        m_ack = 1;
      end else begin
        m_ack = 0;
      end
      for (int b = 0; b < 8; b++) begin
        all_diff = 1;
        for (int k = 0; k < D; k++) begin
          s = hist[hist.size() - 2 - k];
          if (s[b] == m_level[b]) all_diff = 0;
        end
        new_level[b] = all_diff ? ~m_level[b] : m_level[b];
      end
      m_events = (m_events & ~clr) | (new_level & ~m_level);
      m_mask   = new_mask;
      m_level  = new_level;
      hist.push_back(in_pins);
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  end

  // Monitor: ack presence, read data, idle data and irq every cycle
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      checks++;
      if (mem_ready !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL mem_ready t=%0t: got %b expected %b", $time, mem_ready, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mem_rdata !== e) begin
          errors++;
          $display("FAIL rdata t=%0t: got %h expected %h", $time, mem_rdata, e);
        end
      end else begin
        checks++;
        if (mem_rdata !== 32'h0) begin
          errors++;
          $display("FAIL idle_rdata t=%0t: got %h expected 0", $time, mem_rdata);
        end
      end
      checks++;
      if (irq !== (|(m_events & m_mask))) begin
        errors++;
        $display("FAIL irq t=%0t: got %b expected %b", $time, irq, |(m_events & m_mask));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single bus transaction; call and return on a negedge
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
    bit got;
    got       = 0;
    rdata     = '0;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        rdata = mem_rdata;
        got   = 1;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_timeout addr=%h: got no ack expected ack within 20 cycles", addr);
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_xfer(BASE | 32'(off), 32'h0, 4'h0, d);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] d;
    bus_xfer(BASE | 32'(off), data, strb, d);
  endtask

  initial begin : stim
    logic [31:0] d;
    int          acks;
    int          cyc;
    resetn    = 1'b0;
    in_pins   = 8'h00;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset values
    rd_chk("reset_state", 4'h0, 32'h0);
    rd_chk("reset_events", 4'h4, 32'h0);
    rd_chk("reset_mask", 4'h8, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // Held inputs debounce through
    in_pins = 8'h05;
    repeat (10) @(negedge clk);
    rd_chk("state_05", 4'h0, 32'h05);
    rd_chk("events_05", 4'h4, 32'h05);

    // 3-cycle glitch on bit 3 is rejected
    in_pins = 8'h0D;
    repeat (3) @(negedge clk);
    in_pins = 8'h05;
    repeat (10) @(negedge clk);
    rd_chk("glitch_state", 4'h0, 32'h05);
    rd_chk("glitch_events", 4'h4, 32'h05);

    // Mask, irq and W1C
    wr(4'h8, 32'h01, 4'h1);
    chk("irq_masked_on", {31'h0, irq}, 32'h1);
    wr(4'h4, 32'h01, 4'h1);
    chk("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd_chk("events_after_w1c", 4'h4, 32'h04);

    // Set wins over a same-edge W1C on bit 2
    in_pins = 8'h01;
    repeat (10) @(negedge clk);
    wr(4'h4, 32'h04, 4'h1);
    rd_chk("events_cleared", 4'h4, 32'h00);
    in_pins = 8'h05;
    repeat (5) @(negedge clk);
    wr(4'h4, 32'h04, 4'h1);
    rd_chk("set_beats_w1c", 4'h4, 32'h04);

    // Out-of-window access never acknowledged
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h10;
    mem_wstrb = 4'h0;
    acks      = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_ready === 1'b1) acks++;
    end
    mem_valid = 1'b0;
    chk("out_of_window_acks", 32'(acks), 32'h0);

    // STATE is read-only; IRQ_MASK honours byte strobes
    wr(4'h0, 32'hFF, 4'hF);
    rd_chk("state_readonly", 4'h0, 32'h05);
    wr(4'h8, 32'h0, 4'hF);
    wr(4'h8, 32'hFFFF_FFFF, 4'b0010);
    rd_chk("mask_lane1_only", 4'h8, 32'h00);
    wr(4'h8, 32'hFFFF_FFA5, 4'b0001);
    rd_chk("mask_lane0", 4'h8, 32'hA5);
    rd_chk("reserved_reads_0", 4'hC, 32'h0);

    // Reset during a pending request
    in_pins = 8'h00;
    repeat (12) @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h4;
    mem_wstrb = 4'h0;
    resetn    = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        cyc = i;
        break;
      end
    end
    mem_valid = 1'b0;
    chk("ack_after_reset_cycles", 32'(cyc), 32'h1);
    @(negedge clk);
    rd_chk("post_reset_state", 4'h0, 32'h0);
    rd_chk("post_reset_events", 4'h4, 32'h0);
    rd_chk("post_reset_mask", 4'h8, 32'h0);

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          in_pins = 8'($urandom);
          repeat ($urandom_range(1, 7)) @(negedge clk);
        end
        2, 3: bus_xfer(BASE | 32'($urandom_range(0, 15)), $urandom, 4'h0, d);
        4:    bus_xfer(BASE | 32'($urandom_range(0, 15)), $urandom,
                       4'($urandom_range(1, 15)), d);
        default: begin
          mem_valid = 1'b1;
          mem_addr  = ($urandom_range(0, 1) != 0) ? BASE + 32'h10 : 32'h0200_0004;
          mem_wstrb = 4'($urandom_range(0, 15));
          mem_wdata = $urandom;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          mem_valid = 1'b0;
          mem_wstrb = 4'h0;
        end
      endcase
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
